// File: rtl/vga_sprite_capture_pkg.sv
// Shared 640x480 VGA timing constants, capture FSM states and sprite geometry
// used by both the transmit-side and receive-side blocks.
package vga_sprite_capture_pkg;

  localparam int unsigned H_BP     = 144;
  localparam int unsigned H_FP     = 784;
  localparam int unsigned V_BP     = 31;
  localparam int unsigned V_FP     = 511;
  localparam int unsigned H_TOTAL  = 800;

  localparam int unsigned SPR_COLS = 32;
  localparam int unsigned SPR_ROWS = 16;

  localparam int unsigned CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } cap_state_e;

endpackage

// File: rtl/vga_sprite_capture_sync_tracker.sv
// Recovers hc/vc/vidon from sampled hsync/vsync falling edges and flags
// line-length errors; all state advances only on pix_ce.
module vga_sprite_capture_sync_tracker
  import vga_sprite_capture_pkg::*;
#(
  parameter int unsigned HBP    = H_BP,
  parameter int unsigned HFP    = H_FP,
  parameter int unsigned VBP    = V_BP,
  parameter int unsigned VFP    = V_FP,
  parameter int unsigned HTOTAL = H_TOTAL
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             pix_ce_i,
  input  logic             hsync_i,
  input  logic             vsync_i,
  output logic [CNT_W-1:0] hc_o,
  output logic [CNT_W-1:0] vc_o,
  output logic             vidon_o,
  output logic             sync_err_o,
  output logic             hs_fall_o,
  output logic             vs_fall_o
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] HBP_C     = CNT_W'(HBP);
  localparam logic [CNT_W-1:0] HFP_C     = CNT_W'(HFP);
  localparam logic [CNT_W-1:0] VBP_C     = CNT_W'(VBP);
  localparam logic [CNT_W-1:0] VFP_C     = CNT_W'(VFP);
  localparam logic [CNT_W-1:0] HLAST_C   = CNT_W'(HTOTAL - 1);

  logic             hs_prev_q, vs_prev_q;
  logic             seen_edge_q;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             hs_fall, vs_fall;

  // Edge flags are already qualified by pix_ce so the capture FSM can use them directly.
  assign hs_fall = pix_ce_i & hs_prev_q & ~hsync_i;
  assign vs_fall = pix_ce_i & vs_prev_q & ~vsync_i;

  always_comb begin
    hc_d       = hc_q;
    vc_d       = vc_q;
    sync_err_d = sync_err_q;
    if (pix_ce_i) begin
      if (hs_fall)               hc_d = '0;
      else if (hc_q != CNT_MAX)  hc_d = hc_q + 1'b1;

      if (vs_fall)                          vc_d = '0;
      else if (hs_fall && vc_q != CNT_MAX)  vc_d = vc_q + 1'b1;

      if (hs_fall && seen_edge_q && hc_q != HLAST_C) sync_err_d = 1'b1;
      if (hc_d == CNT_MAX)                            sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      seen_edge_q <= 1'b0;
      sync_err_q  <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
    end else if (pix_ce_i) begin
      hs_prev_q   <= hsync_i;
      vs_prev_q   <= vsync_i;
      seen_edge_q <= seen_edge_q | hs_fall;
      sync_err_q  <= sync_err_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
    end
  end

  assign hc_o       = hc_q;
  assign vc_o       = vc_q;
  assign vidon_o    = (hc_q >= HBP_C) && (hc_q < HFP_C) && (vc_q >= VBP_C) && (vc_q < VFP_C);
  assign sync_err_o = sync_err_q;
  assign hs_fall_o  = hs_fall;
  assign vs_fall_o  = vs_fall;

endmodule

// File: rtl/vga_sprite_capture.sv
// Captures a 32x16 one-bit sprite from an incoming VGA stream into a row
// buffer on request, with a registered row read port.
module vga_sprite_capture
  import vga_sprite_capture_pkg::*;
#(
  parameter int unsigned HBP    = H_BP,
  parameter int unsigned HFP    = H_FP,
  parameter int unsigned VBP    = V_BP,
  parameter int unsigned VFP    = V_FP,
  parameter int unsigned HTOTAL = H_TOTAL,
  parameter int unsigned X0     = 0,
  parameter int unsigned Y0     = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pix_ce,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [2:0]       red,
  input  logic [2:0]       green,
  input  logic [1:0]       blue,
  input  logic             arm,
  input  logic [3:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             vidon,
  output logic             busy,
  output logic             done,
  output logic             sync_err
);

  localparam logic [CNT_W-1:0] X_START = CNT_W'(HBP + X0);
  localparam logic [CNT_W-1:0] Y_START = CNT_W'(VBP + Y0);
  localparam logic [CNT_W-1:0] NCOLS   = CNT_W'(SPR_COLS);
  localparam logic [CNT_W-1:0] NROWS   = CNT_W'(SPR_ROWS);

  logic             hs_fall, vs_fall;
  logic [CNT_W-1:0] hc_rel, vc_rel;
  logic [4:0]       wr_col;
  logic [3:0]       wr_row;
  logic             in_win, last_px, wr_en, pix_bit;

  cap_state_e       state_q;
  logic             busy_q, done_q;
  logic [31:0]      rows_q [SPR_ROWS];
  logic [31:0]      rd_data_q;

  vga_sprite_capture_sync_tracker #(
    .HBP    (HBP),
    .HFP    (HFP),
    .VBP    (VBP),
    .VFP    (VFP),
    .HTOTAL (HTOTAL)
  ) u_sync (
    .clk_i      (clk),
    .clr_i      (clr),
    .pix_ce_i   (pix_ce),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .hc_o       (hc),
    .vc_o       (vc),
    .vidon_o    (vidon),
    .sync_err_o (sync_err),
    .hs_fall_o  (hs_fall),
    .vs_fall_o  (vs_fall)
  );

  // Window test uses the counters as they stand at the sampling edge.
  assign hc_rel  = hc - X_START;
  assign vc_rel  = vc - Y_START;
  assign in_win  = (hc >= X_START) && (hc_rel < NCOLS) && (vc >= Y_START) && (vc_rel < NROWS);
  assign wr_col  = hc_rel[4:0];
  assign wr_row  = vc_rel[3:0];
  assign last_px = in_win && (wr_col == 5'd31) && (wr_row == 4'd15);
  assign pix_bit = |{red, green, blue};
  assign wr_en   = (state_q == CAPTURE) && pix_ce && in_win;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pix_ce && arm) begin
            state_q <= WAIT_FRAME;
            busy_q  <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (vs_fall) state_q <= CAPTURE;
        end
        CAPTURE: begin
          // A new frame start restarts capture; the rows simply get overwritten.
          if (!vs_fall && pix_ce && last_px) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < SPR_ROWS; i++) rows_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rows_q[rd_addr];
      if (wr_en) rows_q[wr_row][5'd31 - wr_col] <= pix_bit;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_vga_sprite_capture.sv
// Directed-plus-random bench for vga_sprite_capture against a rule-level
// reference model of the sync recovery, capture FSM and sprite buffer.
module tb_vga_sprite_capture;

  localparam int HBP = 144, HFP = 784, VBP = 31, VFP = 511, HTOTAL = 800;
  localparam int X0 = 0, Y0 = 0;

  logic        clk = 1'b0;
  logic        clr, pix_ce, hsync, vsync, arm;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [9:0]  hc, vc;
  logic        vidon, busy, done, sync_err;

  vga_sprite_capture dut (
    .clk      (clk),
    .clr      (clr),
    .pix_ce   (pix_ce),
    .hsync    (hsync),
    .vsync    (vsync),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .arm      (arm),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .hc       (hc),
    .vc       (vc),
    .vidon    (vidon),
    .busy     (busy),
    .done     (done),
    .sync_err (sync_err)
  );

  always #5 clk = ~clk;

  typedef enum {S_IDLE, S_WAIT, S_CAP, S_DONE} mst_e;

  int          n_pass = 0, n_fail = 0, n_total = 0;
  int          m_hc, m_vc;
  bit          m_hp, m_vp, m_seen, m_err;
  mst_e        m_st;
  logic [31:0] m_rows [16];
  logic [31:0] m_rd;
  logic [31:0] pat [16];
  int          n_done;
  bit          saw_idle, prev_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_hp = 1; m_vp = 1; m_seen = 0; m_err = 0;
    m_st = S_IDLE; m_rd = '0;
    for (int i = 0; i < 16; i++) m_rows[i] = '0;
  endtask

  // Pixel chosen from the sprite pattern when the model counters sit in the window.
  function automatic logic [7:0] pick_pixel();
    int x, y;
    logic [31:0] r;
    x = m_hc - (HBP + X0);
    y = m_vc - (VBP + Y0);
    if (x >= 0 && x < 32 && y >= 0 && y < 16) begin
      r = pat[y];
      return r[31-x] ? 8'($urandom_range(1, 255)) : 8'h00;
    end
    return 8'($urandom);
  endfunction

  task automatic step(input bit ce, input bit hs, input bit vs, input logic [7:0] pix);
    int x, y;
    bit hf, vf;
    pix_ce = ce; hsync = hs; vsync = vs; {red, green, blue} = pix;
    if (clr) model_reset();
    else begin
      m_rd = m_rows[rd_addr];
      hf = ce && m_hp && !hs;
      vf = ce && m_vp && !vs;
      x = m_hc - (HBP + X0);
      y = m_vc - (VBP + Y0);
      if (m_st == S_DONE) m_st = S_IDLE;
      else if (ce) begin
        case (m_st)
          S_IDLE: if (arm) m_st = S_WAIT;
          S_WAIT: if (vf) m_st = S_CAP;
          S_CAP: begin
            if (x >= 0 && x < 32 && y >= 0 && y < 16) m_rows[y][31-x] = (pix != 0);
            if (!vf && x == 31 && y == 15) m_st = S_DONE;
          end
          default: ;
        endcase
      end
      if (ce) begin
        if (hf) begin
          if (m_seen && m_hc != HTOTAL - 1) m_err = 1;
          m_seen = 1;
        end
        if (hf) m_hc = 0;
        else if (m_hc < 1023) m_hc++;
        if (m_hc == 1023) m_err = 1;
        if (vf) m_vc = 0;
        else if (hf && m_vc < 1023) m_vc++;
        m_hp = hs; m_vp = vs;
      end
    end
    @(posedge clk); #1;
    chk("hc", 32'(hc), 32'(m_hc));
    chk("vc", 32'(vc), 32'(m_vc));
    chk("vidon", 32'(vidon), 32'(m_hc >= HBP && m_hc < HFP && m_vc >= VBP && m_vc < VFP));
    chk("busy", 32'(busy), 32'(m_st == S_WAIT || m_st == S_CAP));
    chk("done", 32'(done), 32'(m_st == S_DONE));
    chk("sync_err", 32'(sync_err), 32'(m_err));
    chk("rd_data", rd_data, m_rd);
    if (done === 1'b1) n_done++;
    if (prev_done && busy === 1'b0 && done === 1'b0) saw_idle = 1;
    prev_done = (done === 1'b1);
  endtask

  task automatic drive_line(input int start, input int len, input bit vs, input bit sparse);
    for (int t = start; t < len; t++) begin
      rd_addr = 4'($urandom_range(0, 15));
      step(1'b1, t >= 96, vs, pick_pixel());
      if (sparse) repeat (3) step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) pat[i] = '0;
    pat[0] = 32'hF000000F;
    n_done = 0; saw_idle = 0; prev_done = 0;
    clr = 1'b1; arm = 1'b0; rd_addr = '0;
    pix_ce = 1'b0; hsync = 1'b1; vsync = 1'b1; {red, green, blue} = '0;
    model_reset();

    step(1'b0, 1'b1, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rst_hc", 32'(hc), 32'd0);
    chk("rst_vc", 32'(vc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    clr = 1'b0;

    // Arm held high across the whole capture so the DONE-cycle arm is exercised.
    arm = 1'b1;
    drive_line(0, 800, 1'b1, 1'b0);
    drive_line(0, 800, 1'b1, 1'b1);
    drive_line(0, 800, 1'b1, 1'b0);
    chk("err_clean", 32'(sync_err), 32'd0);
    chk("armed_busy", 32'(busy), 32'd1);

    rd_addr = 4'($urandom_range(0, 15));
    step(1'b1, 1'b0, 1'b0, pick_pixel());
    chk("simul_hc", 32'(hc), 32'd0);
    chk("simul_vc", 32'(vc), 32'd0);
    drive_line(1, 800, 1'b0, 1'b0);
    drive_line(0, 800, 1'b0, 1'b0);
    for (int l = 2; l < 47; l++) drive_line(0, 800, 1'b1, 1'b0);
    chk("done_once", 32'(n_done), 32'd1);
    chk("saw_idle", 32'(saw_idle), 32'd1);
    chk("rearm_busy", 32'(busy), 32'd1);
    arm = 1'b0;

    rd_addr = 4'd0;
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rt_row0", rd_data, 32'hF000000F);
    rd_addr = 4'd1;
    #1;
    chk("rd_hold", rd_data, 32'hF000000F);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("rt_row1", rd_data, 32'h00000000);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step(1'b0, 1'b1, 1'b1, 8'h00);
    end

    drive_line(0, 800, 1'b1, 1'b0);
    drive_line(0, 799, 1'b1, 1'b1);
    chk("err_before", 32'(sync_err), 32'd0);
    drive_line(0, 800, 1'b1, 1'b0);
    chk("short_err", 32'(sync_err), 32'd1);
    drive_line(0, 800, 1'b1, 1'b0);
    chk("err_sticky", 32'(sync_err), 32'd1);

    rd_addr = 4'($urandom_range(0, 15));
    step(1'b1, 1'b0, 1'b0, pick_pixel());
    chk("cap_busy", 32'(busy), 32'd1);
    drive_line(1, 200, 1'b0, 1'b0);
    clr = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h00);
    clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_err", 32'(sync_err), 32'd0);
    chk("clr_hc", 32'(hc), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      step(1'b0, 1'b1, 1'b1, 8'h00);
      chk("clr_row", rd_data, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_sprite_capture.md
VGA_SPRITE_CAPTURE -- requirements
Module: vga_sprite_capture

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- HBP, 144, first active hc value.
- HFP, 784, first hc value past active area.
- VBP, 31, first active vc value.
- VFP, 511, first vc value past active area.
- HTOTAL, 800, expected hc count per line.
- X0, 0, sprite left column, active-area relative.
- Y0, 0, sprite top row, active-area relative.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- clr, in, 1, synchronous active-high reset.
- pix_ce, in, 1, pixel-rate enable (1 in 4 clk at 25 MHz).
- hsync, in, 1, active-low horizontal sync.
- vsync, in, 1, active-low vertical sync.
- red, in, 3, pixel red.
- green, in, 3, pixel green.
- blue, in, 2, pixel blue.
- arm, in, 1, request capture of the next frame.
- rd_addr, in, 4, sprite row select.
- rd_data, out, 32, sprite row bits.
- hc, out, 10, recovered horizontal count.
- vc, out, 10, recovered vertical count.
- vidon, out, 1, recovered active-video flag.
- busy, out, 1, capture in progress.
- done, out, 1, one-clk pulse when capture completes.
- sync_err, out, 1, sticky line-length error.

Function
REQ-003 All inputs other than clk and clr SHALL be sampled only on clk edges where pix_ce=1; on all other cycles, state SHALL hold.
- Exception: rd_data updates every clk.
REQ-004 hc: on a sampled hsync falling edge (previous sample 1, current 0), hc SHALL load 0; otherwise hc SHALL increment, saturating at 1023.
REQ-005 vc: on a sampled hsync falling edge, vc SHALL increment, saturating at 1023; on a sampled vsync falling edge, vc SHALL load 0.
- Simultaneous hsync and vsync edges: the vsync rule wins.
REQ-006 vidon SHALL be 1 iff HBP <= hc < HFP and VBP <= vc < VFP.
- vidon is registered with hc and vc, i.e. it is the combinational decode of the registered counters.
REQ-007 sync_err SHALL set when an hsync falling edge arrives with hc != HTOTAL-1, excluding the first edge after reset.
- sync_err SHALL also set when hc reaches 1023.
- sync_err clears only on clr.
REQ-008 Pixel bit rule: bit = 1 iff {red, green, blue} != 0.
- Sprite pixel (x, y) is the sample with hc = HBP+X0+x and vc = VBP+Y0+y, for x in 0..31 and y in 0..15.
- Column x maps to bit 31-x of row y (MSB is leftmost).
REQ-009 State machine:
- States: IDLE, WAIT_FRAME, CAPTURE, DONE.
- IDLE -> WAIT_FRAME on arm=1.
- WAIT_FRAME -> CAPTURE on a sampled vsync falling edge.
- CAPTURE -> DONE after the sample at (x=31, y=15) is written.
- DONE -> IDLE on the next clk.
REQ-010 In CAPTURE, each pixel bit SHALL be written to the sprite row buffer in the same pix_ce cycle it is sampled.
- The row buffer is 16 x 32 bits.
- The buffer SHALL NOT be written in any other state.
REQ-011 A vsync falling edge during CAPTURE SHALL restart capture for the new frame; the state stays CAPTURE.
REQ-012 arm SHALL be ignored outside IDLE.
- An arm asserted in the DONE cycle SHALL be lost.
REQ-013 busy SHALL be 1 in WAIT_FRAME and CAPTURE.
- done SHALL be 1 only in DONE, for exactly one clk.
REQ-014 rd_data SHALL be registered: it equals row[rd_addr] one clk after rd_addr is presented.
- This read latency holds regardless of pix_ce and capture state.
- A read of the row being written returns the pre-write value.

Reset
REQ-015 On clr=1 at a clk edge, outputs and state SHALL reset as follows:
- hc=0, vc=0, sync_err=0, busy=0, done=0, rd_data=0, state IDLE.
- Sync edge history = 1.
- All 16 rows = 0.
REQ-016 clr SHALL take priority over every other input, including mid-capture, and SHALL abort any capture in progress.

Structure
REQ-017 A shared package SHALL hold the 640x480 timing constants (HBP, HFP, VBP, VFP, HTOTAL), the 4-state enum, and the sprite geometry constants (32 columns, 16 rows).
- Transmit-side and receive-side blocks use the same package.
REQ-018 One sub-module is natural: sync_tracker.
- Contents: edge detection, hc, vc, vidon, sync_err.
- The capture state machine and the row buffer stay in the top module.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Sprite round trip: bench-driven 800x525 timing, sprite row 0 = 0xF000000F, all other rows 0, arm -> after done, rd_addr=0 reads 0xF000000F and rd_addr=1 reads 0x00000000.
- Short line: one line shortened to 799 ticks -> sync_err=1 and stays 1 until clr.
- Mid-capture reset: clr pulsed while in CAPTURE -> busy=0 next clk and every rd_data=0.
- Re-arm: arm held high through DONE -> done pulses once and the state returns to IDLE, then WAIT_FRAME.
- Simultaneous sync edges: hsync and vsync fall together -> vc=0, hc=0.
- Read latency: rd_addr changed with pix_ce=0 -> new rd_data one clk later.
